// File: rtl/ddc_mix_dec_if.sv
// ADC/DDS input and decimated I/Q output bundle for the MSK receive down-converter.
interface ddc_mix_dec_if;
    logic               adc_tvalid;
    logic signed [15:0] adc_tdata;
    logic        [15:0] dds_tdata;
    logic               sat_clr;
    logic               m_tvalid;
    logic signed [15:0] m_tdata_i;
    logic signed [15:0] m_tdata_q;
    logic               sat_flag;

    modport slave (
        input  adc_tvalid, adc_tdata, dds_tdata, sat_clr,
        output m_tvalid, m_tdata_i, m_tdata_q, sat_flag
    );
    modport master (
        output adc_tvalid, adc_tdata, dds_tdata, sat_clr,
        input  m_tvalid, m_tdata_i, m_tdata_q, sat_flag
    );
endinterface

// File: rtl/ddc_mix_dec.sv
// Quadrature mixer followed by a 2^LOG2_DEC boxcar integrate-and-dump per rail,
// with floor scaling and 16-bit saturation of the decimated output.
module ddc_mix_dec #(
    parameter int LOG2_DEC = 2,
    parameter int ACC_W    = 30
) (
    input logic           clk,
    input logic           reset,
    ddc_mix_dec_if.slave  ddc_io
);
    localparam int SH = LOG2_DEC + 7;
    localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] MINV = -ACC_W'(32768);

    // S1: input capture
    logic               v1_q;
    logic signed [15:0] x_q;
    logic signed [7:0]  sin_q, cos_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1_q  <= 1'b0;
            x_q   <= '0;
            sin_q <= '0;
            cos_q <= '0;
        end else begin
            v1_q <= ddc_io.adc_tvalid;
            if (ddc_io.adc_tvalid) begin
                x_q   <= ddc_io.adc_tdata;
                sin_q <= ddc_io.dds_tdata[15:8];
                cos_q <= ddc_io.dds_tdata[7:0];
            end
        end
    end

    // S2: mix; 24-bit holds +2^22 so negating -32768*-128 cannot overflow
    logic               v2_q;
    logic signed [23:0] xe_d, se_d, ce_d, pi_d, pq_d, pi_q, pq_q;

    always_comb begin
        xe_d = 24'(x_q);
        se_d = 24'(sin_q);
        ce_d = 24'(cos_q);
        pi_d = xe_d * ce_d;
        pq_d = -(xe_d * se_d);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v2_q <= 1'b0;
            pi_q <= '0;
            pq_q <= '0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                pi_q <= pi_d;
                pq_q <= pq_d;
            end
        end
    end

    // S3: integrate-and-dump; the dump sum includes the current sample
    logic                      v3_q;
    logic [LOG2_DEC-1:0]       cnt_q;
    logic signed [ACC_W-1:0]   acc_i_q, acc_q_q, sum_i_d, sum_q_d, sum_i_q, sum_q_q;
    logic                      last_d;

    always_comb begin
        sum_i_d = acc_i_q + ACC_W'(pi_q);
        sum_q_d = acc_q_q + ACC_W'(pq_q);
        last_d  = &cnt_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v3_q    <= 1'b0;
            cnt_q   <= '0;
            acc_i_q <= '0;
            acc_q_q <= '0;
            sum_i_q <= '0;
            sum_q_q <= '0;
        end else begin
            v3_q <= v2_q & last_d;
            if (v2_q) begin
                if (last_d) begin
                    sum_i_q <= sum_i_d;
                    sum_q_q <= sum_q_d;
                    acc_i_q <= '0;
                    acc_q_q <= '0;
                    cnt_q   <= '0;
                end else begin
                    acc_i_q <= sum_i_d;
                    acc_q_q <= sum_q_d;
                    cnt_q   <= cnt_q + LOG2_DEC'(1);
                end
            end
        end
    end

    // S4: floor scale and saturate
    logic                    v4_q, hit_q;
    logic signed [ACC_W-1:0] yi_d, yq_d;
    logic signed [15:0]      si_d, sq_d, si_q, sq_q;
    logic                    hit_d;

    always_comb begin
        yi_d  = sum_i_q >>> SH;
        yq_d  = sum_q_q >>> SH;
        si_d  = (yi_d > MAXV) ? 16'sh7FFF : (yi_d < MINV) ? 16'sh8000 : yi_d[15:0];
        sq_d  = (yq_d > MAXV) ? 16'sh7FFF : (yq_d < MINV) ? 16'sh8000 : yq_d[15:0];
        hit_d = (yi_d > MAXV) | (yi_d < MINV) | (yq_d > MAXV) | (yq_d < MINV);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v4_q  <= 1'b0;
            hit_q <= 1'b0;
            si_q  <= '0;
            sq_q  <= '0;
        end else begin
            v4_q <= v3_q;
            if (v3_q) begin
                si_q  <= si_d;
                sq_q  <= sq_d;
                hit_q <= hit_d;
            end
        end
    end

    // Output register: holds between strobes; a saturating strobe beats sat_clr
    logic               m_tvalid_q, sat_flag_q;
    logic signed [15:0] m_i_q, m_q_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_tvalid_q <= 1'b0;
            m_i_q      <= '0;
            m_q_q      <= '0;
            sat_flag_q <= 1'b0;
        end else begin
            m_tvalid_q <= v4_q;
            if (v4_q) begin
                m_i_q <= si_q;
                m_q_q <= sq_q;
            end
            if (v4_q && hit_q)      sat_flag_q <= 1'b1;
            else if (ddc_io.sat_clr) sat_flag_q <= 1'b0;
        end
    end

    assign ddc_io.m_tvalid  = m_tvalid_q;
    assign ddc_io.m_tdata_i = m_i_q;
    assign ddc_io.m_tdata_q = m_q_q;
    assign ddc_io.sat_flag  = sat_flag_q;
endmodule

// File: tb/tb_ddc_mix_dec.sv
// Directed stimulus for ddc_mix_dec, checked every cycle against an arithmetic model
// of mix / block-sum / floor-divide / clamp, plus literal expectations per scenario.
module tb_ddc_mix_dec;
    localparam int L   = 2;
    localparam int DEC = 1 << L;

    logic clk;
    logic reset;
    ddc_mix_dec_if bus();

    ddc_mix_dec #(.LOG2_DEC(L), .ACC_W(30)) dut (.clk(clk), .reset(reset), .ddc_io(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int strobe_cnt = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int floordiv(input int s);
        int d;
        d = 1 << (L + 7);
        if (s >= 0) return s / d;
        return -((-s + d - 1) / d);
    endfunction

    function automatic int clamp(input int y);
        if (y > 32767)  return 32767;
        if (y < -32768) return -32768;
        return y;
    endfunction

    typedef struct { int due; int i; int q; bit sat; } exp_t;

    // Model: a block of DEC valid samples sampled at edge N appears after edge N+4
    initial begin
        exp_t eq[$];
        exp_t e;
        int k = 0, n = 0, ai = 0, aq = 0;
        int exp_i = 0, exp_q = 0, yi, yq, xs, s, c;
        bit exp_v, exp_sat = 0, clr_pend = 0;
        forever begin
            @(negedge clk);
            k++;
            if (!reset) begin
                eq.delete();
                n = 0; ai = 0; aq = 0;
                exp_i = 0; exp_q = 0; exp_sat = 0; clr_pend = 0;
                chk("rst_m_tvalid", bus.m_tvalid, 0);
                chk("rst_m_tdata_i", bus.m_tdata_i, 0);
                chk("rst_m_tdata_q", bus.m_tdata_q, 0);
                chk("rst_sat_flag", bus.sat_flag, 0);
            end else begin
                exp_v = 0;
                if (eq.size() > 0 && eq[0].due == k) begin
                    e = eq.pop_front();
                    exp_v = 1; exp_i = e.i; exp_q = e.q;
                    if (e.sat) exp_sat = 1;
                    else if (clr_pend) exp_sat = 0;
                end else if (clr_pend) exp_sat = 0;
                chk("m_tvalid", bus.m_tvalid, exp_v);
                chk("m_tdata_i", bus.m_tdata_i, exp_i);
                chk("m_tdata_q", bus.m_tdata_q, exp_q);
                chk("sat_flag", bus.sat_flag, exp_sat);
                if (bus.m_tvalid) strobe_cnt++;
                clr_pend = bus.sat_clr;
                if (bus.adc_tvalid) begin
                    xs = bus.adc_tdata;
                    s  = $signed(bus.dds_tdata[15:8]);
                    c  = $signed(bus.dds_tdata[7:0]);
                    ai += xs * c;
                    aq += -(xs * s);
                    n++;
                    if (n == DEC) begin
                        yi = floordiv(ai);
                        yq = floordiv(aq);
                        e.due = k + 5;
                        e.i = clamp(yi);
                        e.q = clamp(yq);
                        e.sat = (e.i != yi) || (e.q != yq);
                        eq.push_back(e);
                        n = 0; ai = 0; aq = 0;
                    end
                end
            end
        end
    end

    task automatic step(input bit v, input logic [15:0] x, input logic [15:0] d, input bit clr);
        @(posedge clk); #1;
        bus.adc_tvalid = v;
        bus.adc_tdata  = x;
        bus.dds_tdata  = d;
        bus.sat_clr    = clr;
    endtask

    task automatic run(input int cnt, input logic [15:0] x, input logic [15:0] d);
        repeat (cnt) step(1, x, d, 0);
    endtask

    task automatic idle(input int cnt);
        repeat (cnt) step(0, 16'h0, 16'h0, 0);
    endtask

    task automatic rst_pulse();
        @(posedge clk); #1;
        reset = 1'b0;
        bus.adc_tvalid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    int base;

    initial begin
        reset = 1'b0;
        bus.adc_tvalid = 1'b0;
        bus.adc_tdata  = '0;
        bus.dds_tdata  = '0;
        bus.sat_clr    = 1'b0;

        // Reset held with toggling inputs
        repeat (6) step(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
        chk("rst_hold_i", bus.m_tdata_i, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        bus.adc_tvalid = 1'b0;
        bus.sat_clr = 1'b0;
        base = strobe_cnt;
        run(3, 16'd1000, 16'h007F);
        idle(8);
        chk("three_samples_no_strobe", strobe_cnt - base, 0);
        rst_pulse();

        // DC on I rail
        base = strobe_cnt;
        run(12, 16'd1000, 16'h007F);
        idle(8);
        chk("dc_strobes", strobe_cnt - base, 3);
        chk("dc_i", bus.m_tdata_i, 992);
        chk("dc_q", bus.m_tdata_q, 0);

        // Q sign, then floor on negative I
        run(4, 16'd1000, 16'h8100);
        idle(8);
        chk("qsign_q", bus.m_tdata_q, 992);
        chk("qsign_i", bus.m_tdata_i, 0);
        run(4, 16'hFC18, 16'h007F);
        idle(8);
        chk("floor_i", bus.m_tdata_i, -993);

        // Saturation, sticky flag, clear, and set-over-clear
        run(4, 16'h8000, 16'h0080);
        idle(8);
        chk("sat_i", bus.m_tdata_i, 32767);
        chk("sat_flag_set", bus.sat_flag, 1);
        idle(4);
        chk("sat_flag_held", bus.sat_flag, 1);
        step(0, 16'h0, 16'h0, 1);
        idle(1);
        chk("sat_flag_cleared", bus.sat_flag, 0);
        run(4, 16'h8000, 16'h0080);
        idle(3);
        step(0, 16'h0, 16'h0, 1);
        idle(1);
        chk("sat_set_beats_clr", bus.sat_flag, 1);
        chk("sat_i_again", bus.m_tdata_i, 32767);
        step(0, 16'h0, 16'h0, 1);
        idle(2);

        // Gapped valid
        base = strobe_cnt;
        repeat (8) begin
            step(1, 16'd1000, 16'h007F, 0);
            step(0, 16'd1000, 16'h007F, 0);
        end
        idle(8);
        chk("gap_strobes", strobe_cnt - base, 2);
        chk("gap_i", bus.m_tdata_i, 992);

        // Reset mid-block discards the partial sum
        run(2, 16'd1000, 16'h007F);
        rst_pulse();
        run(4, 16'd2000, 16'h007F);
        idle(8);
        chk("midrst_i", bus.m_tdata_i, 1984);
        chk("midrst_q", bus.m_tdata_q, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
